// File: rtl/rv_pkg.sv
// Shared RV32I constants for the PC/next-PC logic: branch funct3 codes,
// PC unit state encoding and default vectors.
package rv_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic {
    PCS_RUN  = 1'b0,
    PCS_TRAP = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Bundle between the datapath (master) and the PC unit (slave): request
// inputs and ALU flags in, PC / redirect status out.
interface pc_next_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             stall;
  logic             branch;
  logic [2:0]       branch_op;
  logic             jump;
  logic             jump_reg;
  logic             alu_zero;
  logic             alu_lt;
  logic             alu_ltu;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             taken;
  logic             flush;
  logic             misaligned;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output stall, branch, branch_op, jump, jump_reg,
           alu_zero, alu_lt, alu_ltu, imm, rs1_val,
    input  pc, pc_plus4, taken, flush, misaligned, taken_count
  );

  modport slave (
    input  stall, branch, branch_op, jump, jump_reg,
           alu_zero, alu_lt, alu_ltu, imm, rs1_val,
    output pc, pc_plus4, taken, flush, misaligned, taken_count
  );

endinterface

// File: rtl/pc_next_unit_branch_cond.sv
// Combinational branch condition from funct3 and comparator flags.
// Reserved encodings (010, 011) evaluate as not-taken.
module branch_cond
  import rv_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_BEQ:  cond = alu_zero;
      BR_BNE:  cond = ~alu_zero;
      BR_BLT:  cond = alu_lt;
      BR_BGE:  cond = ~alu_lt;
      BR_BLTU: cond = alu_ltu;
      BR_BGEU: cond = ~alu_ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter unit: owns the PC, resolves branch/jal/jalr redirects,
// traps misaligned targets for one cycle and counts taken redirects.
module pc_next_unit
  import rv_pkg::*;
#(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR     = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR      = XLEN'(DEF_TRAP_VECTOR),
  parameter int              ALLOW_COMPRESSED = 0,
  parameter int              CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  pc_next_unit_if.slave    bus
);

  pc_state_t        state_reg;
  logic [XLEN-1:0]  pc_reg;
  logic             flush_reg;
  logic             misaligned_reg;
  logic [CNT_W-1:0] taken_count_reg;

  logic             cond;
  logic             br_taken;
  logic             taken_next;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  tgt_next;
  logic             mis_next;

  branch_cond u_branch_cond (
    .branch_op (bus.branch_op),
    .alu_zero  (bus.alu_zero),
    .alu_lt    (bus.alu_lt),
    .alu_ltu   (bus.alu_ltu),
    .cond      (cond)
  );

  assign br_taken   = bus.branch & cond;
  // Requests are ignored entirely while the trap cycle is in progress.
  assign taken_next = (state_reg == PCS_RUN) & ~bus.stall &
                      (bus.jump_reg | bus.jump | br_taken);

  assign jalr_sum = bus.rs1_val + bus.imm;
  assign tgt_next = bus.jump_reg ? (jalr_sum & ~XLEN'(1)) : (pc_reg + bus.imm);

  assign mis_next = taken_next &
                    ((ALLOW_COMPRESSED != 0) ? tgt_next[0] : |tgt_next[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= PCS_RUN;
      pc_reg          <= RESET_VECTOR;
      flush_reg       <= 1'b0;
      misaligned_reg  <= 1'b0;
      taken_count_reg <= '0;
    end else begin
      flush_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      case (state_reg)
        PCS_RUN: begin
          if (bus.stall) begin
            pc_reg <= pc_reg;
          end else if (mis_next) begin
            pc_reg         <= TRAP_VECTOR;
            flush_reg      <= 1'b1;
            misaligned_reg <= 1'b1;
            state_reg      <= PCS_TRAP;
          end else if (taken_next) begin
            pc_reg    <= tgt_next;
            flush_reg <= 1'b1;
            if (taken_count_reg != '1) begin
              taken_count_reg <= taken_count_reg + CNT_W'(1);
            end
          end else begin
            pc_reg <= pc_reg + XLEN'(4);
          end
        end
        PCS_TRAP: begin
          if (!bus.stall) begin
            pc_reg    <= TRAP_VECTOR + XLEN'(4);
            state_reg <= PCS_RUN;
          end
        end
        default: state_reg <= PCS_RUN;
      endcase
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.pc_plus4    = pc_reg + XLEN'(4);
  assign bus.taken       = taken_next;
  assign bus.flush       = flush_reg;
  assign bus.misaligned  = misaligned_reg;
  assign bus.taken_count = taken_count_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: expected post-edge state is queued when a
// step is driven and compared after the clock edge.
module tb_pc_next_unit;

  logic clk;
  logic rst;

  pc_next_unit_if #(.XLEN(32), .CNT_W(2)) bus ();

  pc_next_unit #(
    .XLEN             (32),
    .RESET_VECTOR     (32'h0000_0000),
    .TRAP_VECTOR      (32'h0000_0100),
    .ALLOW_COMPRESSED (0),
    .CNT_W            (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic br, input logic [2:0] op,
                      input logic j, input logic jr, input logic z, input logic lt,
                      input logic ltu, input logic [31:0] im, input logic [31:0] rs,
                      input logic e_taken, input logic [31:0] e_pc, input logic e_fl,
                      input logic e_mis, input logic [1:0] e_cnt, input string tag);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.stall     = s;
    bus.branch    = br;
    bus.branch_op = op;
    bus.jump      = j;
    bus.jump_reg  = jr;
    bus.alu_zero  = z;
    bus.alu_lt    = lt;
    bus.alu_ltu   = ltu;
    bus.imm       = im;
    bus.rs1_val   = rs;
    #1;
    chk({tag, ".taken"}, 32'(bus.taken), 32'(e_taken));
    if (!r && !s) chk({tag, ".pc_plus4"}, bus.pc_plus4, bus.pc + 32'd4);
    sb.push_back('{tag, e_pc, e_fl, e_mis, e_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, bus.pc, e.pc);
    chk({e.tag, ".flush"}, 32'(bus.flush), 32'(e.flush));
    chk({e.tag, ".misaligned"}, 32'(bus.misaligned), 32'(e.mis));
    chk({e.tag, ".count"}, 32'(bus.taken_count), 32'(e.cnt));
    $display("step %-12s pc=%h flush=%b mis=%b cnt=%0d", e.tag, bus.pc, bus.flush,
             bus.misaligned, bus.taken_count);
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [1:0] e_cnt, input string tag);
    step(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, e_pc, 0, 0, e_cnt, tag);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 2'd0, "reset");
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.branch = 0; bus.branch_op = 3'b000; bus.jump = 0;
    bus.jump_reg = 0; bus.alu_zero = 0; bus.alu_lt = 0; bus.alu_ltu = 0;
    bus.imm = '0; bus.rs1_val = '0;

    // Reset and sequential fetch
    do_reset();
    idle(32'h4, 0, "idle1");
    idle(32'h8, 0, "idle2");
    idle(32'hC, 0, "idle3");
    for (int i = 4; i <= 16; i++) idle(32'(i * 4), 0, "walk");

    // Conditional branches from pc = 0x40
    step(0,0,1,3'b001,0,0,0,0,0,32'h10,0,        1,32'h50,1,0,2'd1,"bne_taken");
    idle(32'h54, 1, "after_bne");
    step(0,0,1,3'b001,0,0,1,0,0,32'h10,0,        0,32'h58,0,0,2'd1,"bne_not");
    step(0,0,1,3'b100,0,0,0,1,0,32'h8,0,         1,32'h60,1,0,2'd2,"blt");
    step(0,0,1,3'b111,0,0,0,0,0,32'hFFFF_FFE0,0, 1,32'h40,1,0,2'd3,"bgeu");
    step(0,0,1,3'b101,0,0,0,1,0,32'h10,0,        0,32'h44,0,0,2'd3,"bge_not");
    step(0,0,1,3'b000,0,0,1,0,0,32'hC,0,         1,32'h50,1,0,2'd3,"beq_sat");
    step(0,0,1,3'b110,0,0,0,0,0,32'h10,0,        0,32'h54,0,0,2'd3,"bltu_not");
    step(0,0,1,3'b010,0,0,1,1,1,32'h10,0,        0,32'h58,0,0,2'd3,"op010");
    step(0,0,1,3'b011,0,0,1,1,1,32'h10,0,        0,32'h5C,0,0,2'd3,"op011");

    // jalr / jal and request priority
    do_reset();
    step(0,0,0,3'b000,0,1,0,0,0,32'h20,32'h1001,        1,32'h1020,1,0,2'd1,"jalr");
    step(0,0,0,3'b000,0,1,0,0,0,32'h0,32'h200,          1,32'h200,1,0,2'd2,"jalr2");
    step(0,0,0,3'b000,1,0,0,0,0,32'hFFFF_FFF0,32'h0,    1,32'h1F0,1,0,2'd3,"jal_neg");
    step(0,0,1,3'b000,1,1,1,0,0,32'h4,32'h300,          1,32'h304,1,0,2'd3,"prio");

    // Misaligned redirect and trap cycle
    do_reset();
    idle(32'h4, 0, "w4");
    idle(32'h8, 0, "w8");
    idle(32'hC, 0, "wC");
    idle(32'h10, 0, "w10");
    step(0,0,1,3'b000,0,0,1,0,0,32'h6,0,      1,32'h100,1,1,2'd0,"mis_beq");
    step(0,0,0,3'b000,1,0,0,0,0,32'h8,0,      0,32'h104,0,0,2'd0,"trap_ign");
    step(0,0,0,3'b000,0,1,0,0,0,32'h0,32'h302,1,32'h100,1,1,2'd0,"mis_jalr");
    step(0,1,0,3'b000,0,0,0,0,0,32'h0,0,      0,32'h100,0,0,2'd0,"trap_stall");
    step(0,0,0,3'b000,1,0,0,0,0,32'h8,0,      0,32'h104,0,0,2'd0,"trap_exit");
    idle(32'h108, 0, "post_trap");

    // Stall, release, reset priority
    for (int i = 0; i < 3; i++)
      step(0,1,0,3'b000,1,0,0,0,0,32'h8,0,    0,32'h108,0,0,2'd0,"stall");
    step(0,0,0,3'b000,1,0,0,0,0,32'h8,0,      1,32'h110,1,0,2'd1,"release");
    step(0,1,0,3'b000,0,0,0,0,0,32'h0,0,      0,32'h110,0,0,2'd1,"stall_after");
    step(1,0,0,3'b000,1,0,0,0,0,32'h8,0,      1,32'h0,0,0,2'd0,"rst_jump");

    // Back-to-back jal with counter saturation
    for (int i = 1; i <= 5; i++)
      step(0,0,0,3'b000,1,0,0,0,0,32'h10,0,   1,32'(i * 16),1,0,2'((i > 3) ? 3 : i),"jal_b2b");
    idle(32'h54, 3, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
